// File: rtl/jtag_pkg.sv
// ============================================================================
// jtag_pkg : shared constants and types for the JTAG user-chain blocks
// Rev 1.0  : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package jtag_pkg;

  localparam int c_row_w  = 4;
  localparam int c_drop_w = 8;
  localparam logic [c_drop_w-1:0] c_drop_max = '1;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } src_state_t;

  function automatic logic [c_drop_w-1:0] sat_inc(input logic [c_drop_w-1:0] v);
    return (v == c_drop_max) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_sync.sv
// ============================================================================
// bit_sync : single-bit multi-flop synchronizer, asynchronous active-low clear
// Rev 1.0  : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bit_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[DEPTH-2:0], d};
    end
  end

  assign q = r_sync[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/rgb_row_cdc.sv
// ============================================================================
// rgb_row_cdc : moves a JTCK-domain row word into the clk domain with a
//               toggle req/ack handshake around a stable hold register
// Rev 1.0     : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rgb_row_cdc
  import jtag_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ROW_W       = c_row_w
) (
  input  logic                clk,
  input  logic                JTCK,
  input  logic                JRSTN,
  input  logic [ROW_W-1:0]    row_in,
  input  logic                row_upd,
  output logic                busy,
  output logic [c_drop_w-1:0] drop_cnt,
  output logic [ROW_W-1:0]    row_out,
  output logic                row_valid
);

  logic w_rst_n_jtck;
  logic w_rst_n_clk;

  src_state_t          r_state;
  src_state_t          w_state_nxt;
  logic                w_accept;
  logic                w_drop;
  logic                r_req;
  logic [ROW_W-1:0]    r_hold;
  logic [c_drop_w-1:0] r_drop_cnt;
  logic                w_ack_s;

  logic                w_req_s;
  logic                r_req_d;
  logic                r_ack;
  logic [ROW_W-1:0]    r_row_out;
  logic                r_row_valid;
  logic                w_req_edge;

  // Reset asserts asynchronously everywhere, releases on each domain's own clock
  bit_sync #(.DEPTH(2)) u_rst_sync_jtck (
    .clk   (JTCK),
    .rst_n (JRSTN),
    .d     (1'b1),
    .q     (w_rst_n_jtck)
  );

  bit_sync #(.DEPTH(2)) u_rst_sync_clk (
    .clk   (clk),
    .rst_n (JRSTN),
    .d     (1'b1),
    .q     (w_rst_n_clk)
  );

  bit_sync #(.DEPTH(SYNC_STAGES)) u_ack_sync (
    .clk   (JTCK),
    .rst_n (w_rst_n_jtck),
    .d     (r_ack),
    .q     (w_ack_s)
  );

  bit_sync #(.DEPTH(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .rst_n (w_rst_n_clk),
    .d     (r_req),
    .q     (w_req_s)
  );

  always_ff @(posedge JTCK or negedge w_rst_n_jtck) begin
    if (!w_rst_n_jtck) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // An update arriving on the edge that closes the handshake is still a drop
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      IDLE: begin
        if (row_upd) begin
          w_accept    = 1'b1;
          w_state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        w_drop = row_upd;
        if (w_ack_s == r_req) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge JTCK or negedge w_rst_n_jtck) begin
    if (!w_rst_n_jtck) begin
      r_req      <= 1'b0;
      r_hold     <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_hold <= row_in;
        r_req  <= ~r_req;
      end
      if (w_drop) begin
        r_drop_cnt <= sat_inc(r_drop_cnt);
      end
    end
  end

  // r_hold is quiet whenever the req toggle is seen here, so a plain capture is safe
  assign w_req_edge = w_req_s ^ r_req_d;

  always_ff @(posedge clk or negedge w_rst_n_clk) begin
    if (!w_rst_n_clk) begin
      r_req_d     <= 1'b0;
      r_ack       <= 1'b0;
      r_row_out   <= '0;
      r_row_valid <= 1'b0;
    end else begin
      r_req_d     <= w_req_s;
      r_row_valid <= w_req_edge;
      if (w_req_edge) begin
        r_row_out <= r_hold;
        r_ack     <= ~r_ack;
      end
    end
  end

  assign busy      = (r_state == WAIT_ACK);
  assign drop_cnt  = r_drop_cnt;
  assign row_out   = r_row_out;
  assign row_valid = r_row_valid;

endmodule

`default_nettype wire

// File: tb/tb_rgb_row_cdc.sv
// ============================================================================
// tb_rgb_row_cdc : directed and randomized checks of rgb_row_cdc
// Rev 1.0        : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rgb_row_cdc;

  localparam int ROW_W = 4;

  logic             clk     = 1'b0;
  logic             JTCK    = 1'b0;
  logic             JRSTN   = 1'b1;
  logic             row_upd = 1'b0;
  logic [ROW_W-1:0] row_in  = '0;
  logic             busy;
  logic [7:0]       drop_cnt;
  logic [ROW_W-1:0] row_out;
  logic             row_valid;

  int clk_half  = 10;
  int jtck_half = 50;
  bit clk_en    = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  int               valid_cnt = 0;
  int               exp_valid = 0;
  int               exp_drop  = 0;
  logic [ROW_W-1:0] exp_row   = '0;

  rgb_row_cdc #(
    .SYNC_STAGES (2),
    .ROW_W       (ROW_W)
  ) dut (
    .clk       (clk),
    .JTCK      (JTCK),
    .JRSTN     (JRSTN),
    .row_in    (row_in),
    .row_upd   (row_upd),
    .busy      (busy),
    .drop_cnt  (drop_cnt),
    .row_out   (row_out),
    .row_valid (row_valid)
  );

  // clk edges sit at 3 mod 5 ns, JTCK edges at 0 mod 5 ns: never coincident
  initial begin
    #3;
    forever begin
      #(clk_half);
      if (clk_en) clk = ~clk;
    end
  end

  initial begin
    forever begin
      #(jtck_half);
      JTCK = ~JTCK;
    end
  end

  always @(posedge clk) begin
    if (row_valid) valid_cnt <= valid_cnt + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_drop(input int n);
    exp_drop = (exp_drop + n > 255) ? 255 : exp_drop + n;
  endtask

  // Accepted word followed by 'extra' back-to-back updates: the handshake
  // needs at least three JTCK edges to close, so up to three are drops.
  task automatic send(input logic [3:0] w, input int extra, input logic [3:0] dw);
    @(negedge JTCK);
    row_in  = w;
    row_upd = 1'b1;
    @(posedge JTCK);
    exp_row = w;
    exp_valid++;
    for (int i = 0; i < extra; i++) begin
      @(negedge JTCK);
      row_in = dw;
      @(posedge JTCK);
    end
    model_drop(extra);
    @(negedge JTCK);
    row_upd = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(posedge JTCK);
      #1;
      n++;
    end
    chk({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_rv(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (row_valid !== 1'b1 && n < 100);
    chk({tag, " rv seen"}, 32'(row_valid), 32'd1);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, " row_out"},  32'(row_out),  32'(exp_row));
    chk({tag, " drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
    chk({tag, " pulses"},   32'(valid_cnt), 32'(exp_valid));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"},      32'(busy),      32'd0);
    chk({tag, " drop_cnt"},  32'(drop_cnt),  32'd0);
    chk({tag, " row_out"},   32'(row_out),   32'd0);
    chk({tag, " row_valid"}, 32'(row_valid), 32'd0);
  endtask

  initial begin
    #5  JRSTN = 1'b0;
    #20;
    chk_zero("reset");
    #200 JRSTN = 1'b1;
    repeat (4) @(posedge JTCK);

    // 10 MHz JTCK, 50 MHz clk: latency of the capture and single pulse
    @(negedge JTCK);
    row_in  = 4'hA;
    row_upd = 1'b1;
    @(posedge JTCK);
    #1;
    row_upd = 1'b0;
    exp_row = 4'hA;
    exp_valid++;
    chk("s1 busy", 32'(busy), 32'd1);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("s1 rv edge%0d", e), 32'(row_valid), 32'(e == 3));
      if (e == 2) chk("s1 row_out early", 32'(row_out), 32'd0);
      if (e == 3) chk("s1 row_out", 32'(row_out), 32'hA);
    end
    wait_idle("s1");
    settle();
    chk_state("s1");

    // second update while busy is dropped
    send(4'h3, 1, 4'h5);
    wait_idle("s2");
    settle();
    chk_state("s2");

    // update on the very edge busy falls
    @(negedge JTCK);
    row_in  = 4'h9;
    row_upd = 1'b1;
    @(posedge JTCK);
    #1;
    row_upd = 1'b0;
    exp_row = 4'h9;
    exp_valid++;
    wait_rv("s3");
    @(posedge JTCK);
    @(posedge JTCK);
    #1;
    chk("s3 busy before", 32'(busy), 32'd1);
    @(negedge JTCK);
    row_in  = 4'hC;
    row_upd = 1'b1;
    @(posedge JTCK);
    #1;
    row_upd = 1'b0;
    model_drop(1);
    chk("s3 busy fell", 32'(busy), 32'd0);
    repeat (4) @(posedge JTCK);
    #1;
    chk("s3 busy stays", 32'(busy), 32'd0);
    settle();
    chk_state("s3");

    // clk stopped: 300 updates while busy saturate the drop counter
    clk_en = 1'b0;
    @(negedge JTCK);
    row_in  = 4'hE;
    row_upd = 1'b1;
    @(posedge JTCK);
    exp_row = 4'hE;
    exp_valid++;
    repeat (300) @(posedge JTCK);
    #1;
    row_upd = 1'b0;
    model_drop(300);
    chk("s4 drop sat", 32'(drop_cnt), 32'd255);
    chk("s4 busy held", 32'(busy), 32'd1);
    clk_en = 1'b1;
    wait_idle("s4");
    settle();
    chk_state("s4");
    send(4'hB, 2, 4'h0);
    wait_idle("s4b");
    settle();
    chk_state("s4b");

    // reset between req toggle and clk capture aborts the word
    clk_en = 1'b0;
    @(negedge JTCK);
    row_in  = 4'h6;
    row_upd = 1'b1;
    @(posedge JTCK);
    #1;
    row_upd = 1'b0;
    chk("s5 busy", 32'(busy), 32'd1);
    #7 JRSTN = 1'b0;
    #1;
    chk_zero("s5 in reset");
    exp_row  = '0;
    exp_drop = 0;
    #30 JRSTN = 1'b1;
    clk_en = 1'b1;
    repeat (20) @(posedge clk);
    repeat (4) @(posedge JTCK);
    #1;
    chk("s5 busy after", 32'(busy), 32'd0);
    settle();
    chk_state("s5 released");
    send(4'h7, 0, 4'h0);
    wait_idle("s5b");
    settle();
    chk_state("s5b");

    // 20 MHz JTCK, 1 MHz clk
    jtck_half = 25;
    clk_half  = 500;
    send(4'h1, 0, 4'h0); wait_idle("s6a"); settle(); chk_state("s6a");
    send(4'h2, 0, 4'h0); wait_idle("s6b"); settle(); chk_state("s6b");
    send(4'hF, 0, 4'h0); wait_idle("s6c"); settle(); chk_state("s6c");

    // randomized words, drop bursts and clock ratios
    for (int it = 0; it < 16; it++) begin
      case ($urandom_range(0, 2))
        0:       jtck_half = 25;
        1:       jtck_half = 50;
        default: jtck_half = 100;
      endcase
      case ($urandom_range(0, 2))
        0:       clk_half = 10;
        1:       clk_half = 50;
        default: clk_half = 500;
      endcase
      send(4'($urandom), int'($urandom_range(0, 3)), 4'($urandom));
      wait_idle($sformatf("r%0d", it));
      settle();
      chk_state($sformatf("r%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rgb_row_cdc.md
RGB_ROW_CDC -- requirements
Module: rgb_row_cdc

Interface
REQ-001 Parameter: SYNC_STAGES, 2, flip-flop depth of each synchronizer, legal range 2..4.
REQ-002 Parameter: ROW_W, 4, width of the row word.
REQ-003 Port: clk  input  1  system clock, independent of JTCK.
REQ-004 Port: JTCK  input  1  JTAG test clock; clocks the source domain.
REQ-005 Port: JRSTN  input  1  reset, asynchronous, active-low; acts on both domains.
REQ-006 Port: row_in  input  ROW_W  row word from the JTAG user-chain data register (JTCK domain).
REQ-007 Port: row_upd  input  1  JTCK-domain strobe; row_in is valid on this edge.
REQ-008 Port: busy  output  1  JTCK domain; a transfer is in flight.
REQ-009 Port: drop_cnt  output  8  JTCK domain; count of updates rejected while busy.
REQ-010 Port: row_out  output  ROW_W  clk domain; last transferred row word.
REQ-011 Port: row_valid  output  1  clk domain; one-cycle pulse when row_out takes a new value.

Function
REQ-012 The block SHALL move row words from JTCK to clk using a toggle req/ack handshake with a JTCK-domain hold register; it SHALL never sample a multi-bit bus through a synchronizer.
REQ-013 The source FSM SHALL have two states: IDLE (busy=0) and WAIT_ACK (busy=1).
REQ-014 IDLE: on a JTCK edge with row_upd=1, the FSM SHALL load hold<=row_in, toggle req and enter WAIT_ACK on that same edge.
REQ-015 WAIT_ACK: the FSM SHALL return to IDLE on the first JTCK edge where the synchronized ack equals req.
REQ-016 row_upd=1 in WAIT_ACK SHALL leave hold unchanged and increment drop_cnt; drop_cnt SHALL saturate at 255.
REQ-017 row_upd=1 on the same edge that the FSM leaves WAIT_ACK SHALL count as a drop; the request SHALL NOT be accepted.
REQ-018 Destination: req SHALL pass through SYNC_STAGES flops in clk plus one edge-detect flop; when the detector sees a toggle, the same clk edge SHALL load row_out<=hold, assert row_valid and toggle ack.
REQ-019 With SYNC_STAGES=2, row_out and row_valid SHALL update on the 3rd rising clk edge after req changes.
REQ-020 row_valid SHALL be high for exactly one clk cycle per accepted transfer; one transfer SHALL produce one pulse.
REQ-021 ack SHALL pass through SYNC_STAGES flops in JTCK; with SYNC_STAGES=2, busy SHALL fall on the 3rd JTCK edge after ack toggles.
REQ-022 hold SHALL remain stable from the req toggle until busy falls.
REQ-023 row_out SHALL hold its value between transfers, with no glitch.
REQ-024 The design SHALL operate for any ratio of the clk and JTCK frequencies, including JTCK stopped between transfers.

Reset
REQ-025 JRSTN=0 SHALL immediately force the following values: busy=0, FSM=IDLE, req=0, ack=0, hold=0, drop_cnt=0, row_out=0, row_valid=0, and all synchronizer flops to 0.
REQ-026 JRSTN deassertion SHALL be synchronized separately into each domain through a 2-flop reset synchronizer (assert async, release sync).
REQ-027 Reset asserted mid-transfer SHALL abort the transfer; the block SHALL NOT emit a row_valid after release for the aborted word.

Structure
REQ-028 ROW_W default and the drop_cnt width constant SHALL live in the shared package jtag_pkg.
REQ-029 A single sub-module, bit_sync (parameterized depth, async reset), SHALL implement req sync, ack sync and both reset synchronizers.
REQ-030 No other sub-modules SHALL exist; the FSM and the datapath SHALL be in rgb_row_cdc.

Verification
REQ-031 Scenario: clk 50 MHz, JTCK 10 MHz; row_upd with row_in=4'hA -> row_out=4'hA, one row_valid pulse on the 3rd clk edge after req; busy falls afterward.
REQ-032 Scenario: row_upd with 4'h3, then row_upd with 4'h5 on the next JTCK edge while busy -> row_out=4'h3 only; drop_cnt=1; a single row_valid pulse.
REQ-033 Scenario: 300 row_upd pulses issued while busy is held (clk stopped) -> drop_cnt=255, saturated, no wrap.
REQ-034 Scenario: JTCK 20 MHz, clk 1 MHz; sequence 4'h1, 4'h2, 4'hF, each issued after busy falls -> row_out takes each value in order; 3 row_valid pulses.
REQ-035 Scenario: JRSTN pulsed low between the req toggle and the clk capture -> all outputs reset to 0; no row_valid after release; next row_upd 4'h7 transfers normally.
REQ-036 Scenario: row_upd on the same JTCK edge that busy falls -> counted as a drop (drop_cnt +1); row_out unchanged.
